// File: rtl/xmint_prefetch_buffer.sv
// xmint_prefetch_buffer
//
// Instruction prefetch unit sitting between the xmint core front-end and the
// instruction memory port. Issues sequential word fetches on the req/gnt/rvalid
// interface (up to NUM_OUTSTANDING in flight), buffers in-order responses in a
// DEPTH-entry FIFO and presents them to the decoder over valid/ready. A branch
// flushes the FIFO and marks every in-flight response as stale.
//
// Optional build macro: XMINT_PREFETCH_PERF_EN adds saturating 32-bit counters
// perf_fetch_o (granted requests) and perf_discard_o (dropped responses).
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_i                  fetch enable (no new requests while low)
//   branch_i/branch_addr_i single-cycle redirect strobe and target
//   valid_o/ready_i        decoder handshake
//   rdata_o/addr_o/err_o   head FIFO entry (word, its address, bus error)
//   busy_o                 request asserted or responses outstanding
//   instr_req_o/instr_gnt_i/instr_addr_o                memory request channel
//   instr_rvalid_i/instr_rdata_i/instr_err_i            memory response channel
module xmint_prefetch_buffer #(
  parameter int DEPTH           = 4,
  parameter int NUM_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] rdata_o,
  output logic [31:0] addr_o,
  output logic        err_o,
  output logic        busy_o,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  output logic [31:0] instr_addr_o,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i
`ifdef XMINT_PREFETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_o,
  output logic [31:0] perf_discard_o
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OUT_W = $clog2(NUM_OUTSTANDING + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int AQ_W  = (NUM_OUTSTANDING > 1) ? $clog2(NUM_OUTSTANDING) : 1;
  localparam int SUM_W = ((CNT_W > OUT_W) ? CNT_W : OUT_W) + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  // control state
  logic [1:0]       state, state_n;
  logic             addr_valid, addr_valid_n;
  logic             halt, halt_n;
  logic             pend, pend_n;
  logic [31:0]      pend_addr, pend_addr_n;
  logic [31:0]      fetch_addr, fetch_addr_n;
  logic [OUT_W-1:0] outstanding, out_n;
  logic [OUT_W-1:0] discard_cnt, disc_n;
  logic [CNT_W-1:0] fifo_cnt, fifo_cnt_n;
  logic [PTR_W-1:0] wptr, rptr;
  logic [AQ_W-1:0]  aq_wptr, aq_rptr;

  // data storage (not reset)
  logic [31:0]      mem_data [DEPTH];
  logic [31:0]      mem_addr [DEPTH];
  logic             mem_err  [DEPTH];
  logic [31:0]      aq_mem   [NUM_OUTSTANDING];

  logic             grant, drop, push, pop, issue_n;
  logic [OUT_W-1:0] live_n;
  logic [SUM_W-1:0] fill_n;
  logic [31:0]      target;
  logic             unused_addr_lsb;

  assign unused_addr_lsb = ^branch_addr_i[1:0];
  assign target          = {branch_addr_i[31:2], 2'b00};

  function automatic logic [AQ_W-1:0] aq_inc(input logic [AQ_W-1:0] p);
    if (p == AQ_W'(NUM_OUTSTANDING - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign instr_req_o  = (state == ST_REQ);
  assign instr_addr_o = fetch_addr;
  assign busy_o       = instr_req_o | (outstanding != '0);
  assign valid_o      = (fifo_cnt != '0);
  // Head fields are forced to zero while empty so the outputs are defined
  // out of reset even though the storage itself is not reset.
  assign rdata_o      = valid_o ? mem_data[rptr] : '0;
  assign addr_o       = valid_o ? mem_addr[rptr] : '0;
  assign err_o        = valid_o ? mem_err[rptr]  : 1'b0;

  always_comb begin
    grant = instr_req_o & instr_gnt_i;
    // A response is stale if a branch arrives with it or earlier redirects
    // still have responses owed.
    drop  = instr_rvalid_i & (branch_i | (discard_cnt != '0));
    push  = instr_rvalid_i & ~drop;
    pop   = valid_o & ready_i & ~branch_i;
    out_n = outstanding + OUT_W'(grant) - OUT_W'(instr_rvalid_i);

    if (branch_i) begin
      fifo_cnt_n = '0;
      disc_n     = out_n;
    end else begin
      fifo_cnt_n = fifo_cnt + CNT_W'(push) - CNT_W'(pop);
      // A held request that was redirected away becomes a discard once granted.
      disc_n     = discard_cnt - OUT_W'(drop) + OUT_W'(grant & pend);
    end

    pend_n       = pend;
    pend_addr_n  = pend_addr;
    fetch_addr_n = fetch_addr;
    if (grant) begin
      pend_n       = 1'b0;
      fetch_addr_n = pend ? pend_addr : fetch_addr + 32'd4;
    end
    if (branch_i) begin
      if (instr_req_o && !instr_gnt_i) begin
        // Request cannot be retracted: keep its address, park the target.
        pend_n      = 1'b1;
        pend_addr_n = target;
      end else begin
        fetch_addr_n = target;
      end
    end

    addr_valid_n = addr_valid | branch_i;
    halt_n       = branch_i ? 1'b0 : (halt | (push & instr_err_i));

    // Live requests reserve FIFO space so every accepted response fits.
    live_n  = out_n - disc_n;
    fill_n  = SUM_W'(fifo_cnt_n) + SUM_W'(live_n);
    issue_n = addr_valid_n & req_i & ~halt_n &
              (fill_n < SUM_W'(DEPTH)) & (out_n < OUT_W'(NUM_OUTSTANDING));

    state_n = state;
    case (state)
      ST_IDLE: begin
        if (halt_n)       state_n = ST_HALT;
        else if (issue_n) state_n = ST_REQ;
      end
      ST_REQ: begin
        if (grant) state_n = halt_n ? ST_HALT : (issue_n ? ST_REQ : ST_IDLE);
      end
      ST_HALT: begin
        if (branch_i) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= ST_IDLE;
      addr_valid  <= 1'b0;
      halt        <= 1'b0;
      pend        <= 1'b0;
      pend_addr   <= '0;
      fetch_addr  <= '0;
      outstanding <= '0;
      discard_cnt <= '0;
      fifo_cnt    <= '0;
      wptr        <= '0;
      rptr        <= '0;
      aq_wptr     <= '0;
      aq_rptr     <= '0;
    end else begin
      state       <= state_n;
      addr_valid  <= addr_valid_n;
      halt        <= halt_n;
      pend        <= pend_n;
      pend_addr   <= pend_addr_n;
      fetch_addr  <= fetch_addr_n;
      outstanding <= out_n;
      discard_cnt <= disc_n;
      fifo_cnt    <= fifo_cnt_n;
      if (branch_i) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (push) wptr <= wptr + 1'b1;
        if (pop)  rptr <= rptr + 1'b1;
      end
      // The address queue tracks every granted request, stale or not, so it
      // is never flushed.
      if (grant)          aq_wptr <= aq_inc(aq_wptr);
      if (instr_rvalid_i) aq_rptr <= aq_inc(aq_rptr);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_data[wptr] <= instr_rdata_i;
      mem_addr[wptr] <= aq_mem[aq_rptr];
      mem_err[wptr]  <= instr_err_i;
    end
    if (grant) aq_mem[aq_wptr] <= fetch_addr;
  end

`ifdef XMINT_PREFETCH_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_fetch_o   <= '0;
      perf_discard_o <= '0;
    end else begin
      if (grant) perf_fetch_o   <= sat_inc(perf_fetch_o);
      if (drop)  perf_discard_o <= sat_inc(perf_discard_o);
    end
  end
`endif

  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    push |-> (fifo_cnt < CNT_W'(DEPTH)));

  a_no_orphan_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    instr_rvalid_i |-> (outstanding != '0));

endmodule
